// File: rtl/rggen_adapter_core_pkg.sv
// Shared access-type and response-status encodings for the rggen bus adapter.
package rggen_adapter_core_pkg;

  typedef logic [1:0] rggen_access_t;
  typedef logic [1:0] rggen_status_t;

  localparam rggen_access_t RGGEN_POSTED_WRITE = 2'b01;
  localparam rggen_access_t RGGEN_READ         = 2'b10;
  localparam rggen_access_t RGGEN_WRITE        = 2'b11;

  localparam rggen_status_t RGGEN_OKAY   = 2'b00;
  localparam rggen_status_t RGGEN_SLVERR = 2'b10;

  function automatic logic rggen_is_read(rggen_access_t access);
    return access == RGGEN_READ;
  endfunction

  function automatic logic rggen_is_write(rggen_access_t access);
    return (access == RGGEN_WRITE) || (access == RGGEN_POSTED_WRITE);
  endfunction

  // Status reported when nothing answers: decode miss, timeout or out-of-range address.
  function automatic rggen_status_t rggen_error_status(int unsigned error_status);
    return (error_status != 0) ? RGGEN_SLVERR : RGGEN_OKAY;
  endfunction

endpackage

// File: rtl/rggen_mux.sv
// OR-reducing select: every selected entry contributes; one-hot select is the normal case.
module rggen_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 1
) (
  input  logic [ENTRIES-1:0]       select,
  input  logic [WIDTH*ENTRIES-1:0] data,
  output logic [WIDTH-1:0]         result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (select[i]) begin
        result = result | data[i*WIDTH+:WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_adapter_core.sv
// Bus-to-register adapter: decodes the block range, forwards one request at a time to the
// register responders and returns a single-cycle response.
module rggen_adapter_core
  import rggen_adapter_core_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH       = 8,
  parameter int unsigned LOCAL_ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH           = 32,
  parameter int unsigned REGISTERS           = 1,
  parameter int unsigned BASE_ADDRESS        = 0,
  parameter int unsigned BYTE_SIZE           = 256,
  parameter int unsigned ERROR_STATUS        = 0,
  parameter int unsigned TIMEOUT_CYCLES      = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_bus_valid,
  input  logic [1:0]                       i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]         i_bus_address,
  input  logic [BUS_WIDTH-1:0]             i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]           i_bus_strobe,
  output logic                             o_bus_ready,
  output logic [1:0]                       o_bus_status,
  output logic [BUS_WIDTH-1:0]             o_bus_read_data,
  output logic                             o_register_valid,
  output logic [1:0]                       o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_register_address,
  output logic [BUS_WIDTH-1:0]             o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]             i_register_active,
  input  logic [REGISTERS-1:0]             i_register_ready,
  input  logic [2*REGISTERS-1:0]           i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data
);

  localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned LSB          = $clog2(STROBE_WIDTH);
  // One spare bit above the wider of address/base so a below-base address shows as negative.
  localparam int unsigned EXT_WIDTH    = ((ADDRESS_WIDTH > 32) ? ADDRESS_WIDTH : 32) + 1;
  localparam int unsigned COUNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    ~LOCAL_ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
    COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TIMEOUT_ENABLE = (TIMEOUT_CYCLES > 0);
  localparam rggen_status_t ERROR_RESPONSE = rggen_error_status(ERROR_STATUS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] RESPONSE = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]         count_q, count_d;
  rggen_status_t                  status_q, status_d;
  logic [BUS_WIDTH-1:0]           read_data_q, read_data_d;
  rggen_access_t                  access_q;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]           write_data_q;
  logic [STROBE_WIDTH-1:0]        strobe_q;

  logic [EXT_WIDTH-1:0]           offset;
  logic                           in_range;
  logic [LOCAL_ADDRESS_WIDTH-1:0] local_address;
  logic                           accept;
  logic [REGISTERS-1:0]           select;
  logic                           hit;
  logic                           timeout;
  rggen_status_t                  mux_status;
  logic [BUS_WIDTH-1:0]           mux_read_data;

  // Address decode: wrap-around subtraction gives range check and local offset together.
  always_comb begin
    offset        = EXT_WIDTH'(i_bus_address) - EXT_WIDTH'(BASE_ADDRESS);
    in_range      = !offset[EXT_WIDTH-1] && (offset < EXT_WIDTH'(BYTE_SIZE));
    local_address = LOCAL_ADDRESS_WIDTH'(offset) & ADDRESS_MASK;
    accept        = (state_q == IDLE) && i_bus_valid && in_range;
  end

  assign select  = i_register_active & i_register_ready;
  assign hit     = |select;
  assign timeout = TIMEOUT_ENABLE && (count_q == TIMEOUT_LAST);

  rggen_mux #(
    .WIDTH   (2),
    .ENTRIES (REGISTERS)
  ) u_status_mux (
    .select (select),
    .data   (i_register_status),
    .result (mux_status)
  );

  rggen_mux #(
    .WIDTH   (BUS_WIDTH),
    .ENTRIES (REGISTERS)
  ) u_read_data_mux (
    .select (select),
    .data   (i_register_read_data),
    .result (mux_read_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    status_d    = status_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (i_bus_valid) begin
          if (in_range) begin
            state_d = BUSY;
            count_d = '0;
          end else begin
            state_d     = RESPONSE;
            status_d    = ERROR_RESPONSE;
            read_data_d = '0;
          end
        end
      end
      BUSY: begin
        if (hit) begin
          state_d     = RESPONSE;
          status_d    = mux_status;
          read_data_d = mux_read_data;
        end else if ((i_register_active == '0) || timeout) begin
          state_d     = RESPONSE;
          status_d    = ERROR_RESPONSE;
          read_data_d = '0;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      RESPONSE: begin
        state_d     = IDLE;
        count_d     = '0;
        status_d    = '0;
        read_data_d = '0;
      end
      default: begin
        state_d     = IDLE;
        count_d     = '0;
        status_d    = '0;
        read_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      status_q    <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      status_q    <= status_d;
      read_data_q <= read_data_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else if (accept) begin
      access_q     <= i_bus_access;
      address_q    <= local_address;
      write_data_q <= i_bus_write_data;
      strobe_q     <= i_bus_strobe;
    end
  end

  // Status and data registers are zero outside RESPONSE, so they drive the bus directly.
  assign o_bus_ready           = (state_q == RESPONSE);
  assign o_bus_status          = status_q;
  assign o_bus_read_data       = read_data_q;
  assign o_register_valid      = (state_q == BUSY);
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_adapter_core.sv
// Randomised bench for rggen_adapter_core against a transaction-level reference model.
module tb_rggen_adapter_core;
  import rggen_adapter_core_pkg::*;

  localparam int unsigned AW   = 8;
  localparam int unsigned LAW  = 8;
  localparam int unsigned BW   = 32;
  localparam int unsigned REGS = 4;
  localparam int unsigned BASE = 32'h20;
  localparam int unsigned SIZE = 32'h80;
  localparam int unsigned ERR  = 1;
  localparam int unsigned TMO  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bus_valid;
  logic [1:0]           bus_access;
  logic [AW-1:0]        bus_address;
  logic [BW-1:0]        bus_write_data;
  logic [BW/8-1:0]      bus_strobe;
  logic                 bus_ready;
  logic [1:0]           bus_status;
  logic [BW-1:0]        bus_read_data;
  logic                 reg_valid;
  logic [1:0]           reg_access;
  logic [LAW-1:0]       reg_address;
  logic [BW-1:0]        reg_write_data;
  logic [BW/8-1:0]      reg_strobe;
  logic [REGS-1:0]      reg_active;
  logic [REGS-1:0]      reg_ready;
  logic [2*REGS-1:0]    reg_status;
  logic [BW*REGS-1:0]   reg_read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rggen_adapter_core #(
    .ADDRESS_WIDTH       (AW),
    .LOCAL_ADDRESS_WIDTH (LAW),
    .BUS_WIDTH           (BW),
    .REGISTERS           (REGS),
    .BASE_ADDRESS        (BASE),
    .BYTE_SIZE           (SIZE),
    .ERROR_STATUS        (ERR),
    .TIMEOUT_CYCLES      (TMO)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_bus_valid           (bus_valid),
    .i_bus_access          (bus_access),
    .i_bus_address         (bus_address),
    .i_bus_write_data      (bus_write_data),
    .i_bus_strobe          (bus_strobe),
    .o_bus_ready           (bus_ready),
    .o_bus_status          (bus_status),
    .o_bus_read_data       (bus_read_data),
    .o_register_valid      (reg_valid),
    .o_register_access     (reg_access),
    .o_register_address    (reg_address),
    .o_register_write_data (reg_write_data),
    .o_register_strobe     (reg_strobe),
    .i_register_active     (reg_active),
    .i_register_ready      (reg_ready),
    .i_register_status     (reg_status),
    .i_register_read_data  (reg_read_data)
  );

  function automatic logic [127:0] all_outputs();
    return 128'({bus_ready, bus_status, bus_read_data, reg_valid, reg_access, reg_address,
                 reg_write_data, reg_strobe});
  endfunction

  // One bus transaction; the responder raises ready_mask after ready_delay BUSY cycles.
  task automatic run_txn(input string name, input logic [1:0] access, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strobe,
                         input logic [3:0] active, input logic [3:0] ready_mask,
                         input int ready_delay, input logic [7:0] statuses,
                         input logic [127:0] rdata);
    logic [3:0]  sel;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    logic [7:0]  exp_local;
    int          exp_busy;
    int          busy;
    int          resp_cycle;
    bit          got;
    bit          stalled;
    sel        = active & ready_mask;
    exp_status = 2'b00;
    exp_data   = 32'h0;
    exp_local  = 8'((int'(addr) - int'(BASE)) & ~(BW / 8 - 1));
    if (!((int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE + SIZE)))) begin
      exp_busy   = 0;
      exp_status = (ERR != 0) ? 2'b10 : 2'b00;
    end else if (active == 4'h0) begin
      exp_busy   = 1;
      exp_status = (ERR != 0) ? 2'b10 : 2'b00;
    end else if (sel != 4'h0 && ready_delay < int'(TMO)) begin
      exp_busy = ready_delay + 1;
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          exp_status = exp_status | statuses[2*i+:2];
          exp_data   = exp_data | rdata[32*i+:32];
        end
      end
    end else begin
      exp_busy   = int'(TMO);
      exp_status = (ERR != 0) ? 2'b10 : 2'b00;
    end

    @(negedge clk);
    bus_valid      = 1'b1;
    bus_access     = access;
    bus_address    = addr;
    bus_write_data = wdata;
    bus_strobe     = strobe;
    reg_active     = active;
    reg_ready      = 4'h0;
    reg_status     = statuses;
    reg_read_data  = rdata;
    @(negedge clk);
    bus_valid  = 1'b0;
    busy       = 0;
    got        = 1'b0;
    stalled    = 1'b0;
    resp_cycle = 0;
    for (int c = 1; c <= 20 && !got && !stalled; c++) begin
      if (bus_ready) begin
        got        = 1'b1;
        resp_cycle = c;
      end else begin
        checks++;
        if ({bus_status, bus_read_data} !== 34'h0) begin
          failures++;
          $display("FAIL %s idle_bus_outputs: got %h/%h required 0/0", name, bus_status,
                   bus_read_data);
        end
        if (reg_valid) begin
          checks++;
          if ({reg_access, reg_address, reg_write_data, reg_strobe} !==
              {access, exp_local, wdata, strobe}) begin
            failures++;
            $display("FAIL %s register_side: got acc=%b addr=%h wd=%h st=%b required acc=%b addr=%h wd=%h st=%b",
                     name, reg_access, reg_address, reg_write_data, reg_strobe, access,
                     exp_local, wdata, strobe);
          end
          reg_ready = (busy >= ready_delay) ? ready_mask : 4'h0;
          busy++;
        end else begin
          stalled = 1'b1;
        end
        if (!stalled) @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s response_seen: got none (busy=%0d) required o_bus_ready", name, busy);
    end else begin
      checks++;
      if (busy != exp_busy || resp_cycle != exp_busy + 1) begin
        failures++;
        $display("FAIL %s latency: got busy=%0d resp_cycle=%0d required busy=%0d resp_cycle=%0d",
                 name, busy, resp_cycle, exp_busy, exp_busy + 1);
      end
      checks++;
      if (bus_status !== exp_status || bus_read_data !== exp_data) begin
        failures++;
        $display("FAIL %s response: got status=%b data=%h required status=%b data=%h", name,
                 bus_status, bus_read_data, exp_status, exp_data);
      end
      reg_active = 4'h0;
      reg_ready  = 4'h0;
      @(negedge clk);
      checks++;
      if ({bus_ready, bus_status, bus_read_data, reg_valid} !== 36'h0) begin
        failures++;
        $display("FAIL %s one_cycle_response: got ready=%b status=%b data=%h valid=%b required 0",
                 name, bus_ready, bus_status, bus_read_data, reg_valid);
      end
    end
    reg_active = 4'h0;
    reg_ready  = 4'h0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus_valid      = 1'b0;
    bus_access     = 2'b00;
    bus_address    = '0;
    bus_write_data = '0;
    bus_strobe     = '0;
    reg_active     = '0;
    reg_ready      = '0;
    reg_status     = '0;
    reg_read_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outputs() !== 128'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", all_outputs());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outputs() !== 128'h0) begin
      failures++;
      $display("FAIL post_reset_idle: got %h required 0", all_outputs());
    end
  endtask

  task automatic test_read();
    run_txn("read_0x24", RGGEN_READ, 8'(BASE + 4), 32'h0, 4'hF, 4'b0010, 4'b0010, 0, 8'h00,
            {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
  endtask

  task automatic test_write();
    run_txn("write_strobe", RGGEN_WRITE, 8'(BASE + 8), 32'h12345678, 4'b0011, 4'b0100,
            4'b0100, 2, 8'h00, 128'h0);
    run_txn("posted_write", RGGEN_POSTED_WRITE, 8'(BASE + 8'h7F), 32'hCAFEF00D, 4'b1000,
            4'b0001, 4'b0001, 1, 8'h00, 128'h0);
  endtask

  task automatic test_out_of_range();
    run_txn("above_range", RGGEN_READ, 8'(BASE + SIZE), 32'h0, 4'hF, 4'b0001, 4'b0001, 0,
            8'h00, {4{32'h11111111}});
    run_txn("below_range", RGGEN_WRITE, 8'(BASE - 1), 32'h55, 4'hF, 4'b0001, 4'b0001, 0,
            8'h00, 128'h0);
    run_txn("last_in_range", RGGEN_READ, 8'(BASE + SIZE - 1), 32'h0, 4'hF, 4'b1000, 4'b1000,
            0, 8'h00, {32'hA5A5A5A5, 96'h0});
  endtask

  task automatic test_decode_miss();
    run_txn("decode_miss", RGGEN_READ, 8'(BASE + 12), 32'h0, 4'hF, 4'b0000, 4'b1111, 0,
            8'h00, {4{32'hFFFFFFFF}});
  endtask

  task automatic test_timeout();
    run_txn("timeout", RGGEN_READ, 8'(BASE + 16), 32'h0, 4'hF, 4'b0001, 4'b0000, 0, 8'h00,
            {4{32'h77777777}});
    run_txn("ready_at_limit", RGGEN_READ, 8'(BASE + 16), 32'h0, 4'hF, 4'b0001, 4'b0001, 3,
            8'h00, {96'h0, 32'h0BADCAFE});
    run_txn("ready_past_limit", RGGEN_READ, 8'(BASE + 16), 32'h0, 4'hF, 4'b0001, 4'b0001, 4,
            8'h00, {96'h0, 32'h0BADCAFE});
  endtask

  task automatic test_multi_hit();
    run_txn("multi_hit_or", RGGEN_READ, 8'(BASE + 20), 32'h0, 4'hF, 4'b0110, 4'b0110, 1,
            8'b00_10_00_00, {32'h0, 32'hF0F00000, 32'h00000F0F, 32'h0});
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_valid   = 1'b1;
    bus_access  = RGGEN_READ;
    bus_address = 8'(BASE + 4);
    reg_active  = 4'b0001;
    reg_ready   = 4'b0000;
    @(negedge clk);
    bus_valid = 1'b0;
    checks++;
    if (reg_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy: got valid=%b required 1", reg_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h required 0", all_outputs());
    end
    reg_ready = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_ready, reg_valid} !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_no_response: got ready=%b valid=%b required 0/0", bus_ready,
                 reg_valid);
      end
    end
    reg_active = 4'h0;
    reg_ready  = 4'h0;
    run_txn("after_reset", RGGEN_READ, 8'(BASE + 4), 32'h0, 4'hF, 4'b0001, 4'b0001, 0, 8'h00,
            {96'h0, 32'h13572468});
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus_valid   = 1'b1;
    bus_access  = RGGEN_READ;
    bus_address = 8'hF0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus_ready !== 1'((k % 2) == 1)) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got ready=%b required %b", k, bus_ready,
                 1'((k % 2) == 1));
      end
    end
    bus_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]   acc;
    logic [7:0]   addr;
    logic [3:0]   act;
    logic [3:0]   rdy;
    logic [7:0]   sts;
    logic [127:0] data;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       acc = RGGEN_READ;
        1:       acc = RGGEN_WRITE;
        default: acc = RGGEN_POSTED_WRITE;
      endcase
      addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = 8'(BASE + $urandom_range(0, SIZE - 1));
      case ($urandom_range(0, 3))
        0:       act = 4'h0;
        1, 2:    act = 4'(1 << $urandom_range(0, 3));
        default: act = 4'($urandom);
      endcase
      rdy  = ($urandom_range(0, 3) != 0) ? act : 4'($urandom);
      sts  = 8'($urandom) & 8'hAA;
      data = {$urandom, $urandom, $urandom, $urandom};
      run_txn("random", acc, addr, $urandom, 4'($urandom), act, rdy, $urandom_range(0, 5), sts,
              data);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_out_of_range();
    test_decode_miss();
    test_timeout();
    test_multi_hit();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
